// File: rtl/uart_rx_monitor.sv
// rtl/uart_rx_monitor.sv - 8N1 UART receiver feeding a first-word fall-through byte FIFO
// Sticky flags report framing errors, FIFO overflow and arrival of the end-of-test byte.
module uart_rx_monitor #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [7:0]  EOT_CHAR     = 8'h04
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_n_i,
  input  logic                          rx_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  output logic                          eot_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   LEVEL_MAX = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     level_q;
  logic            ferr_q, ovf_q, eot_q;
  logic            rx_s, expire, push, ferr_set, pop, full, wr_en;

  assign rx_s   = sync_q[1];
  assign expire = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = expire ? cnt_q : cnt_q - CW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (expire) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            cnt_d   = FULL_LOAD;
            bit_d   = 3'd0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (expire) begin
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must go high before a new start bit is honoured.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign full  = (level_q == LEVEL_MAX);
  assign pop   = (level_q != '0) && ready_i;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      eot_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (pop)   rptr_q <= rptr_q + AW'(1);
      level_q <= level_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
      if (ferr_set)                  ferr_q <= 1'b1;
      if (push && full && !pop)      ovf_q  <= 1'b1;
      if (push && shift_q == EOT_CHAR) eot_q <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_en) mem_q[wptr_q] <= shift_q;
  end

  assign valid_o     = (level_q != '0);
  assign data_o      = valid_o ? mem_q[rptr_q] : 8'h00;
  assign level_o     = level_q;
  assign frame_err_o = ferr_q;
  assign overflow_o  = ovf_q;
  assign eot_o       = eot_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb/tb_uart_rx_monitor.sv - scoreboard bench for uart_rx_monitor with a queue-based reference model
module tb_uart_rx_monitor;
  localparam int         CPB   = 16;
  localparam int         DEPTH = 4;
  localparam logic [7:0] EOT   = 8'h04;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      rx = 1'b1;
  logic                      ready = 1'b1;
  logic [7:0]                data;
  logic                      valid;
  logic [$clog2(DEPTH):0]    level;
  logic                      ferr, ovf, eot;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic exp_ferr = 1'b0, exp_ovf = 1'b0, exp_eot = 1'b0;

  always #5 clk = ~clk;

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .EOT_CHAR(EOT)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .rx_i(rx),
    .data_o(data), .valid_o(valid), .ready_i(ready), .level_o(level),
    .frame_err_o(ferr), .overflow_o(ovf), .eot_o(eot)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every accepted byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h expected none", data);
      end else begin
        check("rx_byte", {24'h0, data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(b);
    if (b == EOT) exp_eot = 1'b1;
  endtask

  // stop_low = 0 sends a good stop bit; otherwise the line is held low that many cycles.
  task automatic send(input logic [7:0] b, input int stop_low);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    if (stop_low == 0) begin
      model_push(b);
      rx = 1'b1;
      repeat (CPB) tick();
    end else begin
      exp_ferr = 1'b1;
      rx = 1'b0;
      repeat (stop_low) tick();
      rx = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      tick();
      t++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    idle(4);
    check({name, "_level"}, {29'h0, level}, 0);
  endtask

  task automatic check_flags(input string name);
    check({name, "_ferr"}, {31'h0, ferr}, {31'h0, exp_ferr});
    check({name, "_ovf"},  {31'h0, ovf},  {31'h0, exp_ovf});
    check({name, "_eot"},  {31'h0, eot},  {31'h0, exp_eot});
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_data"},  {24'h0, data},  0);
    check({name, "_valid"}, {31'h0, valid}, 0);
    check({name, "_level"}, {29'h0, level}, 0);
    check({name, "_ferr"},  {31'h0, ferr},  0);
    check({name, "_ovf"},   {31'h0, ovf},   0);
    check({name, "_eot"},   {31'h0, eot},   0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] frame;

    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(20);

    send(8'h55, 0);
    idle(20);
    drain("single");
    check_flags("single");

    send(8'h48, 0);
    send(8'h69, 0);
    send(8'h0A, 0);
    idle(20);
    drain("b2b");
    check_flags("b2b");

    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom_range(0, 255));
      if (b == EOT) b = 8'h05;
      send(b, 0);
      idle($urandom_range(0, 30));
    end
    idle(20);
    drain("random");

    ready = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      send(8'(n), 0);
      idle(2);
    end
    idle(20);
    check("ovf_level", {29'h0, level}, DEPTH);
    check("ovf_head", {24'h0, data}, {24'h0, exp_q[0]});
    check_flags("ovf");
    ready = 1'b1;
    drain("ovf");

    rx = 1'b0;
    repeat (6) tick();
    idle(40);
    check("glitch_valid", {31'h0, valid}, 0);
    check_flags("glitch");

    send(8'h33, 40);
    idle(40);
    check("ferr_valid", {31'h0, valid}, 0);
    check_flags("ferr");
    send(8'hA5, 0);
    idle(20);
    drain("after_ferr");

    frame = 8'hF8;
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 3; i++) begin
      rx = frame[i];
      repeat (CPB) tick();
    end
    rx = frame[3];
    repeat (CPB / 2) tick();
    rst_n = 1'b0;
    tick();
    check_all_zero("midreset");
    rst_n = 1'b1;
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
    exp_eot  = 1'b0;
    repeat (CPB / 2) tick();
    for (int i = 4; i < 8; i++) begin
      rx = frame[i];
      repeat (CPB) tick();
    end
    idle(CPB + 20);
    check("midreset_nobyte", {31'h0, valid}, 0);
    send(8'h3C, 0);
    idle(20);
    drain("after_reset");
    check_flags("after_reset");

    send(8'h4F, 0);
    send(8'h4B, 0);
    idle(20);
    check("eot_before", {31'h0, eot}, 0);
    send(EOT, 0);
    idle(20);
    check("eot_set", {31'h0, eot}, 1);
    drain("eot");
    idle(50);
    check_flags("eot_sticky");

    check("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
